// File: rtl/inst_fetch_pkg.sv
// Shared constants, state encoding and queue payload for the instruction-fetch front end.
package inst_fetch_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned INST_W = 32;

   localparam logic [ADDR_W-1:0] ZERO_WORD = 32'h0000_0000;
   localparam logic              CHIP_ENA  = 1'b1;
   localparam logic              CHIP_DISA = 1'b0;

   typedef enum logic [1:0] {
      FETCH_IDLE  = 2'd0,
      FETCH_RUN   = 2'd1,
      FETCH_DSLOT = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [INST_W-1:0] inst;
   } fetch_entry_t;

   function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
      return {a[ADDR_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/inst_fetch_fifo.sv
// Prefetch queue: DEPTH x {pc, inst} circular FIFO with clear and keep-second
// (drop the head, retain only the entry behind it).
module inst_fetch_fifo
   import inst_fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic                     clear_i,
   input  logic                     keep_second_i,
   input  fetch_entry_t             data_i,
   output fetch_entry_t             head_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   fetch_entry_t    mem_q [DEPTH];
   logic [AW-1:0]   rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            do_push, do_pop;

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign head_o  = empty_o ? '0 : mem_q[rd_q];

   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   // Clear wins over keep-second, which wins over ordinary push/pop.
   always_comb begin
      rd_d  = rd_q;
      wr_d  = wr_q;
      cnt_d = cnt_q;
      if (clear_i) begin
         rd_d  = '0;
         wr_d  = '0;
         cnt_d = '0;
      end else if (keep_second_i) begin
         rd_d  = rd_q + AW'(1);
         wr_d  = rd_q + AW'(2);
         cnt_d = CW'(1);
      end else begin
         if (do_push) wr_d = wr_q + AW'(1);
         if (do_pop)  rd_d = rd_q + AW'(1);
         cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !clear_i && !keep_second_i) mem_q[wr_q] <= data_i;
   end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch front end: PC, ROM interface, prefetch queue, branch/flush redirect.
// Define FETCH_STATS_EN to add saturating fetch and squash counters.
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter int unsigned QDEPTH   = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     stall_i,
   input  logic                     flush_i,
   input  logic [ADDR_W-1:0]        new_pc_i,
   input  logic                     branch_flag_i,
   input  logic [ADDR_W-1:0]        branch_target_i,
   output logic                     rom_ce_o,
   output logic [ADDR_W-1:0]        rom_addr_o,
   input  logic [INST_W-1:0]        rom_inst_i,
   output logic                     id_valid_o,
   input  logic                     id_ready_i,
   output logic [ADDR_W-1:0]        id_pc_o,
   output logic [INST_W-1:0]        id_inst_o,
   output logic [$clog2(QDEPTH):0]  q_count_o
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0]              stat_fetched_o,
   output logic [31:0]              stat_squashed_o
`endif
);
   localparam int unsigned CW = $clog2(QDEPTH) + 1;

   fetch_state_e       state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d, tgt_q, tgt_d;
   fetch_entry_t       push_data, head;
   logic [CW-1:0]      count;
   logic               full, empty;
   logic               pop_c, branch_c, multi_c, issue_c, keep_c, clear_c;

   assign pop_c    = ~empty & id_ready_i;
   assign branch_c = branch_flag_i & pop_c;
   assign multi_c  = (count >= CW'(2));
   assign issue_c  = (state_q != FETCH_IDLE) & ~stall_i & (~full | pop_c) & ~flush_i & ~branch_c;
   assign keep_c   = branch_c & multi_c & ~flush_i;
   assign clear_c  = flush_i | (branch_c & ~multi_c);

   assign push_data = {pc_q, rom_inst_i};

   inst_fetch_fifo #(.DEPTH(QDEPTH)) u_fifo (
      .clk           (clk),
      .rst           (rst),
      .push_i        (issue_c),
      .pop_i         (pop_c),
      .clear_i       (clear_c),
      .keep_second_i (keep_c),
      .data_i        (push_data),
      .head_o        (head),
      .count_o       (count),
      .full_o        (full),
      .empty_o       (empty)
   );

   // Redirect priority: flush, then leaving IDLE, then branch, then sequential issue.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      tgt_d   = tgt_q;
      if (flush_i) begin
         state_d = FETCH_RUN;
         pc_d    = word_align(new_pc_i);
         tgt_d   = ZERO_WORD;
      end else if (state_q == FETCH_IDLE) begin
         state_d = FETCH_RUN;
      end else if (branch_c) begin
         if (multi_c) begin
            pc_d = word_align(branch_target_i);
         end else begin
            state_d = FETCH_DSLOT;
            tgt_d   = word_align(branch_target_i);
         end
      end else if (issue_c) begin
         if (state_q == FETCH_DSLOT) begin
            pc_d    = tgt_q;
            state_d = FETCH_RUN;
         end else begin
            pc_d = pc_q + 32'd4;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= FETCH_IDLE;
         pc_q    <= word_align(RESET_PC);
         tgt_q   <= ZERO_WORD;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         tgt_q   <= tgt_d;
      end
   end

   assign rom_ce_o   = issue_c ? CHIP_ENA : CHIP_DISA;
   assign rom_addr_o = pc_q;
   assign id_valid_o = ~empty;
   assign id_pc_o    = head.pc;
   assign id_inst_o  = head.inst;
   assign q_count_o  = count;

`ifdef FETCH_STATS_EN
   logic [31:0]   fetched_q, squashed_q;
   logic [CW-1:0] sq_n_c;
   logic [32:0]   sq_sum_c;

   // Entries thrown away this cycle; the popped branch itself is consumed, not squashed.
   always_comb begin
      sq_n_c = '0;
      if (flush_i)     sq_n_c = count;
      else if (keep_c) sq_n_c = count - CW'(2);
   end

   assign sq_sum_c = {1'b0, squashed_q} + 33'(sq_n_c);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetched_q  <= '0;
         squashed_q <= '0;
      end else begin
         if (issue_c && (fetched_q != '1)) fetched_q <= fetched_q + 32'd1;
         squashed_q <= sq_sum_c[32] ? '1 : sq_sum_c[31:0];
      end
   end

   assign stat_fetched_o  = fetched_q;
   assign stat_squashed_o = squashed_q;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed redirect scenarios plus random traffic
// against a queue-based reference model.
module tb_inst_fetch;
   localparam int unsigned QD  = 4;
   localparam logic [31:0] RPC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_i, flush_i, branch_flag_i, id_ready_i;
   logic [31:0] new_pc_i, branch_target_i;
   logic        rom_ce_o, id_valid_o;
   logic [31:0] rom_addr_o, rom_inst_i, id_pc_o, id_inst_o;
   logic [2:0]  q_count_o;
`ifdef FETCH_STATS_EN
   logic [31:0] stat_fetched_o, stat_squashed_o;
`endif

   inst_fetch #(.QDEPTH(QD), .RESET_PC(RPC)) dut (
      .clk             (clk),
      .rst             (rst),
      .stall_i         (stall_i),
      .flush_i         (flush_i),
      .new_pc_i        (new_pc_i),
      .branch_flag_i   (branch_flag_i),
      .branch_target_i (branch_target_i),
      .rom_ce_o        (rom_ce_o),
      .rom_addr_o      (rom_addr_o),
      .rom_inst_i      (rom_inst_i),
      .id_valid_o      (id_valid_o),
      .id_ready_i      (id_ready_i),
      .id_pc_o         (id_pc_o),
      .id_inst_o       (id_inst_o),
      .q_count_o       (q_count_o)
`ifdef FETCH_STATS_EN
      ,
      .stat_fetched_o  (stat_fetched_o),
      .stat_squashed_o (stat_squashed_o)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rom_f(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
   endfunction

   assign rom_inst_i = rom_f(rom_addr_o);

   int n_vec = 0;
   int n_err = 0;

   // Reference model: delivered-instruction queue, fetch PC, mode 0=idle 1=run 2=delay-slot pending
   logic [31:0] mq_pc[$];
   logic [31:0] mq_in[$];
   logic [31:0] m_pc, m_tgt, m_fet, m_sq;
   int          m_mode;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq_pc.delete();
      mq_in.delete();
      m_pc   = RPC;
      m_tgt  = 32'h0;
      m_mode = 0;
      m_fet  = 32'h0;
      m_sq   = 32'h0;
   endtask

   task automatic do_reset();
      #2 rst = 1'b0;
      #1;
      model_reset();
      chk("rst_rom_ce", 32'(rom_ce_o), 32'h0);
      chk("rst_rom_addr", rom_addr_o, RPC);
      chk("rst_id_valid", 32'(id_valid_o), 32'h0);
      chk("rst_id_pc", id_pc_o, 32'h0);
      chk("rst_id_inst", id_inst_o, 32'h0);
      chk("rst_q_count", 32'(q_count_o), 32'h0);
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   task automatic step(input logic st, input logic fl, input logic [31:0] np,
                       input logic br, input logic [31:0] bt, input logic rdy);
      int sz;
      logic pop, brk, iss;
      logic [31:0] kp, ki;
      stall_i = st; flush_i = fl; new_pc_i = np;
      branch_flag_i = br; branch_target_i = bt; id_ready_i = rdy;
      @(negedge clk);
      sz  = mq_pc.size();
      pop = (sz > 0) && rdy;
      brk = br && pop;
      iss = (m_mode != 0) && !st && ((sz < int'(QD)) || pop) && !fl && !brk;
      chk("rom_ce", 32'(rom_ce_o), 32'(iss));
      chk("rom_addr", rom_addr_o, m_pc);
      chk("id_valid", 32'(id_valid_o), 32'(sz > 0));
      chk("q_count", 32'(q_count_o), 32'(sz));
      if (sz > 0) begin
         chk("id_pc", id_pc_o, mq_pc[0]);
         chk("id_inst", id_inst_o, mq_in[0]);
      end else begin
         chk("id_pc_empty", id_pc_o, 32'h0);
         chk("id_inst_empty", id_inst_o, 32'h0);
      end
`ifdef FETCH_STATS_EN
      chk("stat_fetched", stat_fetched_o, m_fet);
      chk("stat_squashed", stat_squashed_o, m_sq);
`endif
      if (iss) m_fet = m_fet + 1;
      if (fl) begin
         m_sq = m_sq + 32'(sz);
         mq_pc.delete(); mq_in.delete();
         m_pc = {np[31:2], 2'b00};
         m_tgt = 32'h0;
         m_mode = 1;
      end else if (m_mode == 0) begin
         m_mode = 1;
      end else if (brk) begin
         void'(mq_pc.pop_front()); void'(mq_in.pop_front());
         if (mq_pc.size() > 0) begin
            m_sq = m_sq + 32'(mq_pc.size() - 1);
            kp = mq_pc[0]; ki = mq_in[0];
            mq_pc.delete(); mq_in.delete();
            mq_pc.push_back(kp); mq_in.push_back(ki);
            m_pc = {bt[31:2], 2'b00};
         end else begin
            m_mode = 2;
            m_tgt = {bt[31:2], 2'b00};
         end
      end else begin
         if (pop) begin
            void'(mq_pc.pop_front()); void'(mq_in.pop_front());
         end
         if (iss) begin
            mq_pc.push_back(m_pc);
            mq_in.push_back(rom_f(m_pc));
            if (m_mode == 2) begin
               m_pc = m_tgt;
               m_mode = 1;
            end else begin
               m_pc = m_pc + 32'd4;
            end
         end
      end
      @(posedge clk); #1;
   endtask

   initial begin
      logic st, rdy, fl, br;
      logic [31:0] sq0;
      rst = 1'b0;
      stall_i = 1'b0; flush_i = 1'b0; branch_flag_i = 1'b0; id_ready_i = 1'b0;
      new_pc_i = 32'h0; branch_target_i = 32'h0;
      model_reset();
      do_reset();

      // Start-up stream with ID always ready
      for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 1);

      // Back-pressure: queue fills to QDEPTH, then drains
      step(0, 1, 32'h40, 0, 0, 0);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 0);
      chk("fill_count", 32'(q_count_o), 32'd4);
      chk("fill_ce_off", 32'(rom_ce_o), 32'h0);
      for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 1);

      // Branch with entries behind head, combined with stall
      step(0, 1, 32'h10, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
      sq0 = m_sq;
      step(1, 0, 0, 1, 32'h100, 1);
      chk("br_keep_head", id_pc_o, 32'h14);
      chk("br_keep_count", 32'(q_count_o), 32'd1);
      step(0, 0, 0, 0, 0, 1);
      chk("br_target_head", id_pc_o, 32'h100);
`ifdef FETCH_STATS_EN
      chk("br_squash_delta", stat_squashed_o, sq0 + 32'd1);
`endif
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1);

      // Branch with nothing behind head: delay slot fetched afterwards, stall in DSLOT
      step(0, 1, 32'h300, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 1, 32'h203, 1);
      step(1, 0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      chk("dslot_head", id_pc_o, 32'h304);
      step(0, 0, 0, 0, 0, 1);
      chk("dslot_target_head", id_pc_o, 32'h200);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);

      // Flush on a full queue, misaligned handler address
      for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0);
      step(0, 1, 32'h183, 0, 0, 0);
      chk("flush_count", 32'(q_count_o), 32'd0);
      step(0, 0, 0, 0, 0, 1);
      chk("flush_head", id_pc_o, 32'h180);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);

      // Flush while a delay slot is pending
      step(0, 1, 32'h500, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 1, 32'h700, 1);
      step(0, 1, 32'h600, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      chk("flush_dslot_head", id_pc_o, 32'h600);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1);

      // PC wraps modulo 2^32
      step(0, 1, 32'hFFFF_FFF8, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      chk("wrap_pre", id_pc_o, 32'hFFFF_FFFC);
      step(0, 0, 0, 0, 0, 1);
      chk("wrap_zero", id_pc_o, 32'h0);
      step(0, 0, 0, 0, 0, 1);

      // Reset in the middle of traffic
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
      do_reset();
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         st  = ($urandom_range(3) == 0);
         rdy = ($urandom_range(3) != 0);
         fl  = ($urandom_range(39) == 0);
         br  = ($urandom_range(4) == 0) && rdy && (mq_pc.size() > 0);
         step(st, fl, $urandom, br, $urandom, rdy);
      end
      for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
